// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues instruction-memory reads and loads IF/ID.
// Holds a one-entry skid buffer for words returned during a stall and a pending-redirect register.
module fetch_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        ifW,
  input  logic        ifRST,
  input  logic        jr_en,
  input  logic        jmp_en,
  input  logic        br_en,
  input  logic [31:0] jr_target,
  input  logic [31:0] jmp_target,
  input  logic [31:0] br_target,
  input  logic        halt,
  output logic [31:0] if_instr,
  output logic [31:0] if_npc,
  output logic        if_valid,
  output logic        halted
);

  typedef enum logic [0:0] {StFetch, StHalt} state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic        skid_valid_q;
  logic [31:0] skid_instr_q;
  logic [31:0] skid_npc_q;
  logic        pend_valid_q;
  logic [31:0] pend_target_q;
  logic [31:0] if_instr_q;
  logic [31:0] if_npc_q;
  logic        if_valid_q;

  logic        redir;
  logic [31:0] redir_target;
  logic        req;
  logic        hit;
  logic        good;
  logic [31:0] pc_plus4;
  logic [31:0] pc_next;

  always_comb begin
    redir        = jr_en | jmp_en | br_en;
    redir_target = jr_en ? jr_target : (jmp_en ? jmp_target : br_target);
    req          = (state_q == StFetch) && !skid_valid_q;
    // A return only counts when a request is actually outstanding.
    hit          = req && ihit;
    good         = hit && !redir && !pend_valid_q;
    pc_plus4     = pc_q + 32'd4;
    if (redir) begin
      pc_next = redir_target;
    end else if (pend_valid_q) begin
      pc_next = pend_target_q;
    end else begin
      pc_next = pc_plus4;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q       <= StFetch;
      pc_q          <= PC_RESET;
      skid_valid_q  <= 1'b0;
      skid_instr_q  <= NOP_WORD;
      skid_npc_q    <= 32'h0;
      pend_valid_q  <= 1'b0;
      pend_target_q <= 32'h0;
      if_instr_q    <= NOP_WORD;
      if_npc_q      <= 32'h0;
      if_valid_q    <= 1'b0;
    end else if (state_q == StFetch) begin
      if (halt) begin
        // Halt wins over everything; all other state freezes.
        state_q <= StHalt;
      end else begin
        if (hit) begin
          pc_q         <= pc_next;
          pend_valid_q <= 1'b0;
        end else if (redir) begin
          // pc must not move while a request is outstanding; remember the target.
          pend_valid_q  <= 1'b1;
          pend_target_q <= redir_target;
        end

        if (ifRST) begin
          if_instr_q   <= NOP_WORD;
          if_npc_q     <= 32'h0;
          if_valid_q   <= 1'b0;
          skid_valid_q <= 1'b0;
        end else if (skid_valid_q) begin
          if (ifW) begin
            if_instr_q   <= skid_instr_q;
            if_npc_q     <= skid_npc_q;
            if_valid_q   <= 1'b1;
            skid_valid_q <= 1'b0;
          end
        end else if (good) begin
          if (ifW) begin
            if_instr_q <= imemload;
            if_npc_q   <= pc_plus4;
            if_valid_q <= 1'b1;
          end else begin
            skid_instr_q <= imemload;
            skid_npc_q   <= pc_plus4;
            skid_valid_q <= 1'b1;
          end
        end else if (ifW) begin
          if_instr_q <= NOP_WORD;
          if_npc_q   <= 32'h0;
          if_valid_q <= 1'b0;
        end
      end
    end
  end

  assign imemREN  = req;
  assign imemaddr = pc_q;
  assign if_instr = if_instr_q;
  assign if_npc   = if_npc_q;
  assign if_valid = if_valid_q;
  assign halted   = (state_q == StHalt);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage: one vector per clock, plus reset sequences.
module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ihit;
  logic [31:0] imemload;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ifW;
  logic        ifRST;
  logic        jr_en, jmp_en, br_en;
  logic [31:0] jr_target, jmp_target, br_target;
  logic        halt;
  logic [31:0] if_instr;
  logic [31:0] if_npc;
  logic        if_valid;
  logic        halted;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  fetch_stage dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .ihit       (ihit),
    .imemload   (imemload),
    .imemREN    (imemREN),
    .imemaddr   (imemaddr),
    .ifW        (ifW),
    .ifRST      (ifRST),
    .jr_en      (jr_en),
    .jmp_en     (jmp_en),
    .br_en      (br_en),
    .jr_target  (jr_target),
    .jmp_target (jmp_target),
    .br_target  (br_target),
    .halt       (halt),
    .if_instr   (if_instr),
    .if_npc     (if_npc),
    .if_valid   (if_valid),
    .halted     (halted)
  );

  typedef struct {
    logic [31:0] ihit, load, ifw, ifrst, rd, jt, mt, bt, hlt_in;
    logic [31:0] e_ren, e_addr, e_instr, e_npc, e_valid, e_halted;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    logic [31:0] ih, ld, fw, fr, rd, jt, mt, bt, hi,
    logic [31:0] er, ea, ei, en, ev, eh);
    vec_t v;
    v.ihit = ih; v.load = ld; v.ifw = fw; v.ifrst = fr; v.rd = rd;
    v.jt = jt; v.mt = mt; v.bt = bt; v.hlt_in = hi;
    v.e_ren = er; v.e_addr = ea; v.e_instr = ei; v.e_npc = en; v.e_valid = ev; v.e_halted = eh;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] er, ea, ei, en, ev, eh);
    chk({tag, " imemREN"},  {31'b0, imemREN}, er);
    chk({tag, " imemaddr"}, imemaddr, ea);
    chk({tag, " if_instr"}, if_instr, ei);
    chk({tag, " if_npc"},   if_npc, en);
    chk({tag, " if_valid"}, {31'b0, if_valid}, ev);
    chk({tag, " halted"},   {31'b0, halted}, eh);
  endtask

  task automatic drive(input vec_t v);
    ihit       = v.ihit[0];
    imemload   = v.load;
    ifW        = v.ifw[0];
    ifRST      = v.ifrst[0];
    jr_en      = v.rd[2];
    jmp_en     = v.rd[1];
    br_en      = v.rd[0];
    jr_target  = v.jt;
    jmp_target = v.mt;
    br_target  = v.bt;
    halt       = v.hlt_in[0];
  endtask

  task automatic idle_inputs();
    drive(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  initial begin
    // ihit load ifW ifRST {jr,jmp,br} jr_t jmp_t br_t halt | REN addr instr npc valid halted
    tbl.push_back(mk(1, 32'h2001000A, 1, 0, 0, 0, 0, 0, 0, 1, 32'h4, 32'h2001000A, 32'h4, 1, 0));
    tbl.push_back(mk(1, 32'h20020005, 1, 0, 0, 0, 0, 0, 0, 1, 32'h8, 32'h20020005, 32'h8, 1, 0));
    tbl.push_back(mk(1, 32'hAAAA0001, 1, 0, 0, 0, 0, 0, 0, 1, 32'hC, 32'hAAAA0001, 32'hC, 1, 0));
    tbl.push_back(mk(1, 32'hAAAA0002, 1, 0, 0, 0, 0, 0, 0, 1, 32'h10, 32'hAAAA0002, 32'h10, 1, 0));
    // stall at pc 0x10: word goes to skid, request drops
    tbl.push_back(mk(1, 32'hBBBB0010, 0, 0, 0, 0, 0, 0, 0, 0, 32'h14, 32'hAAAA0002, 32'h10, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h14, 32'hAAAA0002, 32'h10, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 32'h14, 32'hBBBB0010, 32'h14, 1, 0));
    tbl.push_back(mk(1, 32'hCCCC0014, 1, 0, 0, 0, 0, 0, 0, 1, 32'h18, 32'hCCCC0014, 32'h18, 1, 0));
    tbl.push_back(mk(1, 32'hCCCC0018, 1, 0, 0, 0, 0, 0, 0, 1, 32'h1C, 32'hCCCC0018, 32'h1C, 1, 0));
    tbl.push_back(mk(1, 32'hCCCC001C, 1, 0, 0, 0, 0, 0, 0, 1, 32'h20, 32'hCCCC001C, 32'h20, 1, 0));
    // pending branch while 0x20 outstanding
    tbl.push_back(mk(0, 0, 1, 0, 3'b001, 0, 0, 32'h80, 0, 1, 32'h20, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 32'h20, 0, 0, 0, 0));
    tbl.push_back(mk(1, 32'hDEAD0020, 1, 0, 0, 0, 0, 0, 0, 1, 32'h80, 0, 0, 0, 0));
    tbl.push_back(mk(1, 32'h11110080, 1, 0, 0, 0, 0, 0, 0, 1, 32'h84, 32'h11110080, 32'h84, 1, 0));
    // pending target overwritten; IF/ID held with ifW=0
    tbl.push_back(mk(0, 0, 0, 0, 3'b010, 0, 32'h200, 0, 0, 1, 32'h84, 32'h11110080, 32'h84, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 3'b001, 0, 0, 32'h300, 0, 1, 32'h84, 32'h11110080, 32'h84, 1, 0));
    tbl.push_back(mk(1, 32'hDEAD0084, 0, 0, 0, 0, 0, 0, 0, 1, 32'h300, 32'h11110080, 32'h84, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 32'h300, 0, 0, 0, 0));
    // priority jr > jmp > br
    tbl.push_back(mk(1, 32'hDEAD0300, 1, 0, 3'b111, 32'h100, 32'h200, 32'h300, 0,
                     1, 32'h100, 0, 0, 0, 0));
    tbl.push_back(mk(1, 32'h22220100, 1, 0, 0, 0, 0, 0, 0, 1, 32'h104, 32'h22220100, 32'h104, 1, 0));
    // skid full, then flush with ifW=1
    tbl.push_back(mk(1, 32'h33330104, 0, 0, 0, 0, 0, 0, 0, 0, 32'h108, 32'h22220100, 32'h104, 1, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 32'h108, 0, 0, 0, 0));
    tbl.push_back(mk(1, 32'h44440108, 1, 1, 0, 0, 0, 0, 0, 1, 32'h10C, 0, 0, 0, 0));
    tbl.push_back(mk(1, 32'h5555010C, 1, 0, 0, 0, 0, 0, 0, 1, 32'h110, 32'h5555010C, 32'h110, 1, 0));
    // pc+4 wraps
    tbl.push_back(mk(1, 32'hDEAD0110, 1, 0, 3'b010, 0, 32'hFFFFFFFC, 0, 0,
                     1, 32'hFFFFFFFC, 0, 0, 0, 0));
    tbl.push_back(mk(1, 32'h6666FFFC, 1, 0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h6666FFFC, 32'h0, 1, 0));
    // halt at pc 0x40, together with a redirect; later ihit/ifRST ignored
    tbl.push_back(mk(1, 32'hDEAD0000, 1, 0, 3'b010, 0, 32'h3C, 0, 0, 1, 32'h3C, 0, 0, 0, 0));
    tbl.push_back(mk(1, 32'h7777003C, 1, 0, 0, 0, 0, 0, 0, 1, 32'h40, 32'h7777003C, 32'h40, 1, 0));
    tbl.push_back(mk(1, 32'hDEAD0040, 1, 0, 3'b100, 32'h500, 0, 0, 1,
                     0, 32'h40, 32'h7777003C, 32'h40, 1, 1));
    tbl.push_back(mk(1, 32'hDEAD0041, 1, 0, 0, 0, 0, 0, 0, 0, 32'h40, 32'h7777003C, 32'h40, 1, 1));
    tbl.push_back(mk(1, 32'hDEAD0042, 1, 1, 0, 0, 0, 0, 0, 0, 32'h40, 32'h7777003C, 32'h40, 1, 1));

    nRST = 1'b0;
    idle_inputs();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    chk_all("reset", 1, 32'h0, 32'h0, 32'h0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge CLK);
      drive(tbl[i]);
      @(posedge CLK);
      #1;
      chk_all($sformatf("v%0d", i), tbl[i].e_ren, tbl[i].e_addr, tbl[i].e_instr,
              tbl[i].e_npc, tbl[i].e_valid, tbl[i].e_halted);
    end

    // Asynchronous reset out of HALT.
    @(negedge CLK);
    idle_inputs();
    #2 nRST = 1'b0;
    #1;
    chk_all("halt_reset", 1, 32'h0, 32'h0, 32'h0, 0, 0);
    @(negedge CLK);
    nRST = 1'b1;

    // Redirect pends at pc 0, then reset mid-fetch must drop the pending target.
    br_en = 1'b1; br_target = 32'h80; ihit = 1'b0;
    @(posedge CLK);
    #1;
    chk("pend_hold addr", imemaddr, 32'h0);
    @(negedge CLK);
    idle_inputs();
    #2 nRST = 1'b0;
    #1;
    chk_all("midfetch_reset", 1, 32'h0, 32'h0, 32'h0, 0, 0);
    @(negedge CLK);
    nRST = 1'b1;
    ihit = 1'b1; imemload = 32'h88880000;
    @(posedge CLK);
    #1;
    chk_all("post_reset", 1, 32'h4, 32'h88880000, 32'h4, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline: owns the PC, drives the instruction-memory request and loads the IF/ID pipeline register.
- Consumes the hazard unit's IF-stage controls `ifW` (write enable) and `ifRST` (flush) plus redirect requests from decode/execute.
- Contains a 1-entry skid buffer for words returned during a stall and a pending-redirect register for redirects that arrive mid-fetch.

Parameters:
- PC_RESET, 32'h0000_0000, PC value loaded on reset.
- NOP_WORD, 32'h0000_0000, instruction word inserted into IF/ID for bubbles/flushes.

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- nRST  in  1  asynchronous active-low reset
- ihit  in  1  instruction memory returned a word this cycle
- imemload  in  32  returned instruction word, valid when ihit=1
- imemREN  out  1  instruction read request
- imemaddr  out  32  instruction read address
- ifW  in  1  IF/ID write enable from hazard unit
- ifRST  in  1  IF/ID flush from hazard unit
- jr_en, jmp_en, br_en  in  1 each  redirect requests
- jr_target, jmp_target, br_target  in  32 each  redirect addresses, full byte addresses
- halt  in  1  HALT decoded; stop fetching
- if_instr  out  32  IF/ID instruction
- if_npc  out  32  IF/ID PC+4 of that instruction
- if_valid  out  1  IF/ID holds a real instruction
- halted  out  1  fetch stopped

Behaviour:
- Reset (async, nRST=0):
  - pc=PC_RESET; state=FETCH.
  - if_instr=NOP_WORD, if_npc=0, if_valid=0.
  - skid_valid=0, pend_valid=0, halted=0.
- States are FETCH and HALT.
  - FETCH: imemREN = !skid_valid; imemaddr = pc.
  - HALT: imemREN=0, halted=1; left only by reset.
- Redirect: redir = jr_en|jmp_en|br_en.
  - Priority jr > jmp > br; target is that of the highest-priority asserted request.
  - Sampled every cycle in FETCH.
  - The fetch in flight when redir is seen is wrong-path and is never delivered.
- Address stability: pc and imemaddr do not change while a request is outstanding (imemREN=1, ihit=0).
  - A redirect during that window sets pend_valid=1, pend_target=target; pc holds.
  - A later redirect before ihit overwrites pend_target.
- On ihit=1 in FETCH, the next pc is chosen in this order:
  1. Redirect this cycle: its target.
  2. Else pend_valid: pend_target.
  3. Else pc+4 (wraps modulo 2^32).
  - pend_valid clears.
  - The word is discarded if redir or pend_valid was set; otherwise it is "good".
- Good word, ifW=1, skid empty: IF/ID <= {imemload, pc+4, valid=1}.
- Good word, ifW=0: skid <= {imemload, pc+4}, skid_valid=1; IF/ID holds. imemREN drops the following cycle.
- Skid full and ifW=1: IF/ID <= skid contents, valid=1; skid_valid=0; fetch resumes the next cycle.
- Discarded word, ifW=1, no ifRST: IF/ID <= bubble {NOP_WORD, 0, valid=0}.
- Discarded word, ifW=0: IF/ID holds.
- No ihit and no skid, ifW=1: IF/ID <= bubble.
- ifRST=1 (highest priority on IF/ID, overrides ifW, including ifW=1 & ifRST=1 together):
  - IF/ID <= bubble.
  - skid_valid <= 0.
  - pc update on the same edge still follows the rules above.
- halt=1 in FETCH: next state HALT; pc, IF/ID, skid and pending register freeze. Any ihit after entering HALT is ignored.
- Simultaneous halt and redirect: halt wins; pc is not updated.
- Reset mid-fetch: all state returns to reset values asynchronously; imemREN re-asserts at PC_RESET on the first cycle after release.

Test Plan:
- Reset release, ifW=1, ihit=1 every cycle, imemload=0x2001000A,0x20020005: imemaddr 0,4,8; IF/ID shows {0x2001000A, npc 4, valid 1} then {0x20020005, npc 8}.
- Stall with skid:
  - ihit=1 with ifW=0 at pc=0x10 loads skid; imemREN=0 next cycle; IF/ID unchanged.
  - ifW=1 two cycles later: IF/ID={word, npc 0x14}; imemaddr=0x14 with imemREN=1 the cycle after.
- Pending redirect: pc=0x20 outstanding (ihit=0), br_en=1, br_target=0x80 for one cycle.
  - imemaddr stays 0x20 until ihit.
  - Returned word discarded (if_valid=0); next imemaddr=0x80.
- Priority: jr_en, jmp_en, br_en all asserted with ihit=1, targets 0x100/0x200/0x300: next imemaddr=0x100.
- Flush: ifRST=1 and ifW=1 with a good word and skid full: IF/ID valid=0, instr=NOP_WORD; skid_valid=0.
- Halt: halt=1 at pc=0x40: halted=1 next cycle, imemREN=0 permanently; ihit pulses ignored. nRST low then high: pc=PC_RESET, halted=0.
